// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with a tear-free shadow/commit handshake.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int PW       = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [3:0]            dec_in,
    output logic [DIGITS-1:0]     anode_n,
    output logic                  pending,
    output logic                  frame_ack
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PW-1:0]       count, count_next;
    logic [IW-1:0]       index, index_next;
    logic                running;
    logic [4*DIGITS-1:0] shown, shown_next, shadow;
    logic                tick, frame_end, commit;
    logic [3:0]          nibble_next;
    logic [DIGITS-1:0]   anode_next;

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0]   blank, blank_next, zero_mask;
    logic                all_zero;
`endif

    always_comb begin
        // running is low on the first enabled edge so slot 0 starts with a full prescale period
        tick       = running && enable && (count == PW'(PRESCALE - 1));
        frame_end  = tick && (index == IW'(DIGITS - 1));
        commit     = pending && (frame_end || !enable);
        count_next = '0;
        index_next = '0;
        if (enable && running) begin
            count_next = tick ? '0 : count + 1'b1;
            index_next = index;
            if (tick) begin
                index_next = frame_end ? '0 : index + 1'b1;
            end
        end
        shown_next  = commit ? shadow : shown;
        nibble_next = shown_next[{index_next, 2'b00} +: 4];
        anode_next  = ~(DIGITS'(1) << index_next);
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        zero_mask = '0;
        all_zero  = 1'b1;
        for (int unsigned k = 0; k < DIGITS - 1; k++) begin
            all_zero                       = all_zero && (shadow[4*(DIGITS-1-k) +: 4] == 4'h0);
            zero_mask[DIGITS-1-k]          = all_zero;
        end
        blank_next = commit ? zero_mask : blank;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blank <= '0;
        end else begin
            blank <= blank_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            index     <= '0;
            running   <= 1'b0;
            shown     <= '1;
            shadow    <= '1;
            pending   <= 1'b0;
            frame_ack <= 1'b0;
            anode_n   <= '1;
            dec_in    <= 4'hF;
        end else begin
            count     <= count_next;
            index     <= index_next;
            running   <= enable;
            shown     <= shown_next;
            if (load) begin
                shadow <= value;
            end
            pending   <= load || (pending && !commit);
            frame_ack <= commit;
            anode_n   <= enable ? anode_next : '1;
`ifdef LEADING_ZERO_BLANK_EN
            dec_in    <= !enable ? 4'hF : (blank_next[index_next] ? 4'hF : nibble_next);
`else
            dec_in    <= enable ? nibble_next : 4'hF;
`endif
        end
    end

endmodule
